// File: rtl/dht11_responder.sv
// ---- dht11_responder: DHT11 sensor-side responder (start detect, handshake, 40-bit frame) ----
// ---- rev 1.0 ------------------------------------------------------------------------------------
`default_nettype none

module dht11_responder #(
  parameter int unsigned US_DIV         = 50,
  parameter int unsigned T_START_MIN_US = 18000,
  parameter int unsigned T_WAIT_US      = 30,
  parameter int unsigned T_RESP_US      = 80,
  parameter int unsigned T_BIT_LOW_US   = 50,
  parameter int unsigned T_ZERO_US      = 26,
  parameter int unsigned T_ONE_US       = 70,
  parameter int unsigned T_GLITCH_US    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [31:0] data_in,
  input  logic        load,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  checksum,
  output logic        err_short,
  output logic        err_collision
);

  localparam int unsigned PW          = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned T_SUM       = T_START_MIN_US + T_WAIT_US + T_RESP_US + T_BIT_LOW_US
                                        + T_ZERO_US + T_ONE_US;
  localparam int unsigned CW          = $clog2(T_SUM + 1);
  localparam int unsigned GLITCH_CLKS = T_GLITCH_US * US_DIV;
  localparam int unsigned GW          = $clog2(GLITCH_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOST_LOW, S_WAIT, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
  } state_e;

  state_e         state_q, state_d;
  logic           dq_meta_q, dq_s_q, dq_dly_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic [CW-1:0]  us_cnt_q, us_cnt_d;
  logic [1:0]     ign_q, ign_d;
  logic [GW-1:0]  glitch_q, glitch_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic [39:0]    shift_q, shift_d;
  logic [31:0]    shadow_q, shadow_d;
  logic [7:0]     checksum_q, checksum_d;
  logic           dq_oe_q, dq_oe_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           err_short_q, err_short_d;
  logic           err_coll_q, err_coll_d;

  logic           us_tick, phase_done, released, glitch_hit, entry;
  logic [CW-1:0]  phase_last;
  logic [7:0]     sum;

  // Pad is pulled up, so the synchroniser resets to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_meta_q <= 1'b1;
      dq_s_q    <= 1'b1;
      dq_dly_q  <= 1'b1;
    end else begin
      dq_meta_q <= dq_in;
      dq_s_q    <= dq_meta_q;
      dq_dly_q  <= dq_s_q;
    end
  end

  always_comb begin
    sum     = shadow_q[31:24] + shadow_q[23:16] + shadow_q[15:8] + shadow_q[7:0];
    us_tick = (presc_q == PW'(US_DIV - 1));

    phase_last = CW'(0);
    case (state_q)
      S_WAIT:                phase_last = CW'(T_WAIT_US - 1);
      S_RESP_LOW,
      S_RESP_HIGH:           phase_last = CW'(T_RESP_US - 1);
      S_BIT_LOW, S_END_LOW:  phase_last = CW'(T_BIT_LOW_US - 1);
      S_BIT_HIGH:            phase_last = shift_q[39] ? CW'(T_ONE_US - 1) : CW'(T_ZERO_US - 1);
      default:               phase_last = CW'(0);
    endcase
    phase_done = us_tick && (us_cnt_q == phase_last);

    // The first two cycles after a release still show our own low through the synchroniser.
    released   = (state_q == S_WAIT) || (state_q == S_RESP_HIGH) || (state_q == S_BIT_HIGH);
    glitch_hit = released && (ign_q == 2'd2) && !dq_s_q && (glitch_q == GW'(GLITCH_CLKS - 1));

    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    checksum_d   = checksum_q;
    shadow_d     = load ? data_in : shadow_q;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;
    err_coll_d   = 1'b0;

    case (state_q)
      S_IDLE:      if (dq_dly_q && !dq_s_q) state_d = S_HOST_LOW;
      S_HOST_LOW: begin
        if (dq_s_q) begin
          if (us_cnt_q >= CW'(T_START_MIN_US)) begin
            state_d = S_WAIT;
          end else begin
            state_d     = S_IDLE;
            err_short_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (phase_done) begin
          state_d    = S_RESP_LOW;
          shift_d    = {shadow_q, sum};
          checksum_d = sum;
        end
      end
      S_RESP_LOW:  if (phase_done) state_d = S_RESP_HIGH;
      S_RESP_HIGH: begin
        if (phase_done) begin
          state_d   = S_BIT_LOW;
          bit_cnt_d = 6'd0;
        end
      end
      S_BIT_LOW:   if (phase_done) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (phase_done) begin
          shift_d   = {shift_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW: begin
        if (phase_done) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default:     state_d = S_IDLE;
    endcase

    if (glitch_hit) begin
      state_d    = S_IDLE;
      err_coll_d = 1'b1;
    end

    // Every phase starts with a fresh prescaler and counter so durations are exact.
    entry    = (state_d != state_q);
    presc_d  = (entry || us_tick) ? '0 : presc_q + PW'(1);
    us_cnt_d = entry ? '0 : ((us_tick && (us_cnt_q != '1)) ? us_cnt_q + CW'(1) : us_cnt_q);
    ign_d    = entry ? 2'd0 : ((ign_q == 2'd2) ? 2'd2 : ign_q + 2'd1);
    glitch_d = (entry || dq_s_q || (ign_q != 2'd2)) ? '0
             : ((glitch_q != '1) ? glitch_q + GW'(1) : glitch_q);

    dq_oe_d = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) || (state_d == S_END_LOW);
    busy_d  = (state_d != S_IDLE) && (state_d != S_HOST_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      us_cnt_q     <= '0;
      ign_q        <= 2'd0;
      glitch_q     <= '0;
      bit_cnt_q    <= 6'd0;
      shift_q      <= 40'd0;
      shadow_q     <= 32'd0;
      checksum_q   <= 8'd0;
      dq_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_coll_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      us_cnt_q     <= us_cnt_d;
      ign_q        <= ign_d;
      glitch_q     <= glitch_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      shadow_q     <= shadow_d;
      checksum_q   <= checksum_d;
      dq_oe_q      <= dq_oe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      err_coll_q   <= err_coll_d;
    end
  end

  assign dq_oe         = dq_oe_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign checksum      = checksum_q;
  assign err_short     = err_short_q;
  assign err_collision = err_coll_q;

endmodule

`default_nettype wire

// File: tb/tb_dht11_responder.sv
// ---- tb_dht11_responder: directed self-checking bench for dht11_responder ----
`default_nettype none

module tb_dht11_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_low = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        dq_in;
  logic        dq_oe, busy, frame_done, err_short, err_collision;
  logic [7:0]  checksum;

  int n_checks = 0;
  int n_pass   = 0;

  // Open-drain wired-AND of host and responder with an external pull-up.
  assign dq_in = ~(host_low | dq_oe);

  always #5 clk = ~clk;

  dht11_responder #(
    .US_DIV(1), .T_START_MIN_US(180), .T_WAIT_US(30), .T_RESP_US(80),
    .T_BIT_LOW_US(50), .T_ZERO_US(26), .T_ONE_US(70), .T_GLITCH_US(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dq_in(dq_in), .dq_oe(dq_oe), .data_in(data_in), .load(load),
    .busy(busy), .frame_done(frame_done), .checksum(checksum), .err_short(err_short),
    .err_collision(err_collision)
  );

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic count_run(input logic val, output int len);
    len = 0;
    while (dq_oe === val && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic host_start(input int low_clks);
    host_low = 1'b1;
    repeat (low_clks) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic recv_frame(input string name, input logic [39:0] exp);
    int          len, n, bad, first_bad;
    logic [39:0] got;
    got = 40'd0; bad = 0; first_bad = 0; n = 0;
    while (dq_oe !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (dq_oe !== 1'b1) begin
      $display("FAIL %s_resp_start: dq_oe=%b, required 1 within 200 clks", name, dq_oe);
      return;
    end
    n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b, required 1", name, busy);
    else n_pass++;
    count_run(1'b1, len);
    n_checks++;
    if (len !== 80) $display("FAIL %s_resp_low: got %0d clks, required 80", name, len);
    else n_pass++;
    count_run(1'b0, len);
    n_checks++;
    if (len !== 80) $display("FAIL %s_resp_high: got %0d clks, required 80", name, len);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      count_run(1'b1, len);
      if (len !== 50) begin
        if (bad == 0) first_bad = len;
        bad++;
      end
      count_run(1'b0, len);
      got[39-i] = (len > 48);
      if (len !== (exp[39-i] ? 70 : 26)) begin
        if (bad == 0) first_bad = len;
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL %s_bit_timing: %0d bad widths, first width %0d clks", name, bad, first_bad);
    else n_pass++;
    n_checks++;
    if (got !== exp) $display("FAIL %s_data: got %h, required %h", name, got, exp);
    else n_pass++;
    count_run(1'b1, len);
    n_checks++;
    if (len !== 50) $display("FAIL %s_end_low: got %0d clks, required 50", name, len);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL %s_frame_done: got %b, required 1", name, frame_done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_busy_end: got %b, required 0", name, busy);
    else n_pass++;
    n_checks++;
    if (checksum !== exp[7:0]) $display("FAIL %s_checksum: got %h, required %h", name, checksum, exp[7:0]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL %s_frame_done_pulse: got %b, required 0", name, frame_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dq_oe, busy, frame_done, err_short, err_collision, checksum} !== 13'd0)
      $display("FAIL reset_outputs: got %b, required all zero",
               {dq_oe, busy, frame_done, err_short, err_collision, checksum});
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame_basic();
    do_load(32'h3C001900);
    host_start(200);
    recv_frame("basic", 40'h3C00190055);
  endtask

  task automatic test_all_ones();
    do_load(32'hFFFFFFFF);
    host_start(200);
    recv_frame("ones", 40'hFFFFFFFFFC);
  endtask

  task automatic test_short_start();
    int errs, oe_any, busy_any;
    errs = 0; oe_any = 0; busy_any = 0;
    host_start(150);
    for (int k = 0; k < 60; k++) begin
      if (err_short === 1'b1) errs++;
      if (dq_oe !== 1'b0) oe_any++;
      if (busy !== 1'b0) busy_any++;
      @(negedge clk);
    end
    n_checks++;
    if (errs !== 1) $display("FAIL short_err_pulse: got %0d cycles, required 1", errs);
    else n_pass++;
    n_checks++;
    if (oe_any !== 0) $display("FAIL short_dq_oe: got %0d cycles driven, required 0", oe_any);
    else n_pass++;
    n_checks++;
    if (busy_any !== 0) $display("FAIL short_busy: got %0d cycles busy, required 0", busy_any);
    else n_pass++;
    host_start(200);
    recv_frame("after_short", 40'hFFFFFFFFFC);
  endtask

  task automatic test_collision();
    int len, colls, oe_any;
    colls = 0; oe_any = 0;
    do_load(32'hA5A5A5A5);
    host_start(200);
    len = 0;
    while (dq_oe !== 1'b1 && len < 200) begin
      len++;
      @(negedge clk);
    end
    count_run(1'b1, len);
    count_run(1'b0, len);
    for (int i = 0; i < 10; i++) begin
      count_run(1'b1, len);
      count_run(1'b0, len);
    end
    count_run(1'b1, len);
    repeat (5) @(negedge clk);
    host_low = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) host_low = 1'b0;
      @(negedge clk);
      if (err_collision === 1'b1) colls++;
    end
    n_checks++;
    if (colls !== 1) $display("FAIL coll_pulse: got %0d cycles, required 1", colls);
    else n_pass++;
    n_checks++;
    if (dq_oe !== 1'b0) $display("FAIL coll_dq_oe: got %b, required 0", dq_oe);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL coll_busy: got %b, required 0", busy);
    else n_pass++;
    for (int k = 0; k < 200; k++) begin
      if (dq_oe !== 1'b0) oe_any++;
      @(negedge clk);
    end
    n_checks++;
    if (oe_any !== 0) $display("FAIL coll_quiet: got %0d cycles driven, required 0", oe_any);
    else n_pass++;
  endtask

  task automatic test_load_race();
    host_start(200);
    repeat (32) @(negedge clk);
    n_checks++;
    if (dq_oe !== 1'b0) $display("FAIL race_pre: dq_oe got %b, required 0", dq_oe);
    else n_pass++;
    data_in = 32'h11223344;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    n_checks++;
    if (dq_oe !== 1'b1) $display("FAIL race_entry: dq_oe got %b, required 1", dq_oe);
    else n_pass++;
    recv_frame("race_old", 40'hA5A5A5A594);
    host_start(200);
    recv_frame("race_new", 40'h11223344AA);
  endtask

  task automatic test_reset_mid_frame();
    int len, oe_any, busy_any;
    oe_any = 0; busy_any = 0; len = 0;
    host_start(200);
    while (dq_oe !== 1'b1 && len < 200) begin
      len++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dq_oe !== 1'b0) $display("FAIL rst_mid_dq_oe: got %b, required 0", dq_oe);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || checksum !== 8'd0)
      $display("FAIL rst_mid_state: busy %b checksum %h, required 0 and 00", busy, checksum);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (dq_oe !== 1'b0) oe_any++;
      if (busy !== 1'b0) busy_any++;
      @(negedge clk);
    end
    n_checks++;
    if (oe_any !== 0 || busy_any !== 0)
      $display("FAIL rst_mid_quiet: driven %0d busy %0d cycles, required 0", oe_any, busy_any);
    else n_pass++;
    host_start(200);
    recv_frame("post_reset", 40'h0000000000);
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_all_ones();
    test_short_start();
    test_collision();
    test_load_race();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
